// File: rtl/my_processor_nios2_qsys_dct_controller.sv
// Compressed-trace (DCT) sequencing controller.
//
// Packs 2-bit trace symbols LSB-first into a 30-bit word (slot i at bits [2i+1:2i]).
// A word is handed to a one-entry output register when it holds MaxCount symbols, or
// earlier on a flush. The output register is drained over a valid/ready handshake.
// The trace source cannot stall. A symbol that arrives while both stages are full is
// dropped and counted.
//
// Ports:
//   clk_i, reset_ni   clock, asynchronous active-low reset
//   trace_valid_i     symbol present this cycle
//   trace_sym_i       2-bit symbol value
//   flush_i           pulse: emit the partial word
//   out_ready_i       sink accepts the output word this cycle
//   ovf_clr_i         clear ovf_o and drop_count_o
//   out_valid_o       output register holds a word
//   dct_buffer_o      packed symbols, unused upper bits zero
//   dct_count_o       number of valid symbols (1..MaxCount)
//   out_flushed_o     word was emitted by a flush rather than by filling up
//   ovf_o             sticky: at least one symbol dropped
//   drop_count_o      dropped-symbol count, saturating at 255
module my_processor_nios2_qsys_dct_controller #(
  parameter int unsigned MaxCount = 15
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        trace_valid_i,
  input  logic [1:0]  trace_sym_i,
  input  logic        flush_i,
  input  logic        out_ready_i,
  input  logic        ovf_clr_i,
  output logic        out_valid_o,
  output logic [29:0] dct_buffer_o,
  output logic [3:0]  dct_count_o,
  output logic        out_flushed_o,
  output logic        ovf_o,
  output logic [7:0]  drop_count_o
);

  localparam logic [3:0] MaxCnt = 4'(MaxCount);

  typedef enum logic {StFill, StFull} acc_state_e;

  logic [29:0] acc_q, acc_d;
  logic [3:0]  acc_cnt_q, acc_cnt_d;
  logic        flush_pend_q, flush_pend_d;
  logic        out_valid_q, out_valid_d;
  logic [29:0] buf_q, buf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        flushed_q, flushed_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  drop_q, drop_d;

  acc_state_e  acc_state;
  logic        out_free;
  logic        flush_act;
  logic        drop;
  logic        complete;
  logic [29:0] sym_word;
  logic [29:0] new_acc;
  logic [3:0]  new_cnt;

  assign acc_state = (acc_cnt_q == MaxCnt) ? StFull : StFill;
  // Output register can take a word if empty or being drained this same cycle.
  assign out_free  = !out_valid_q || out_ready_i;
  assign flush_act = flush_i || flush_pend_q;
  assign sym_word  = 30'(trace_sym_i) << {acc_cnt_q, 1'b0};

  always_comb begin
    acc_d        = acc_q;
    acc_cnt_d    = acc_cnt_q;
    flush_pend_d = flush_pend_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    flushed_d    = flushed_q;
    out_valid_d  = out_valid_q && !out_ready_i;
    drop         = 1'b0;
    new_acc      = acc_q;
    new_cnt      = acc_cnt_q;
    complete     = 1'b0;

    unique case (acc_state)
      StFill: begin
        if (trace_valid_i) begin
          new_acc = acc_q | sym_word;
          new_cnt = acc_cnt_q + 4'd1;
        end
        complete = (new_cnt == MaxCnt);
        if ((complete || (flush_act && new_cnt != 4'd0)) && out_free) begin
          buf_d        = new_acc;
          cnt_d        = new_cnt;
          flushed_d    = !complete;
          out_valid_d  = 1'b1;
          acc_d        = '0;
          acc_cnt_d    = '0;
          flush_pend_d = 1'b0;
        end else begin
          acc_d        = new_acc;
          acc_cnt_d    = new_cnt;
          // A flush on an empty accumulator is simply consumed.
          flush_pend_d = flush_act && (new_cnt != 4'd0);
        end
      end
      StFull: begin
        if (out_free) begin
          buf_d        = acc_q;
          cnt_d        = MaxCnt;
          flushed_d    = 1'b0;
          out_valid_d  = 1'b1;
          flush_pend_d = 1'b0;
          // Symbol arriving on the draining cycle starts the next word at slot 0.
          acc_d        = trace_valid_i ? 30'(trace_sym_i) : '0;
          acc_cnt_d    = trace_valid_i ? 4'd1 : 4'd0;
        end else begin
          flush_pend_d = flush_act;
          drop         = trace_valid_i;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (ovf_clr_i) begin
      ovf_d  = drop;
      drop_d = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hff) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      buf_q        <= '0;
      cnt_q        <= '0;
      flushed_q    <= 1'b0;
      ovf_q        <= 1'b0;
      drop_q       <= '0;
    end else begin
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      flushed_q    <= flushed_d;
      ovf_q        <= ovf_d;
      drop_q       <= drop_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign dct_buffer_o  = buf_q;
  assign dct_count_o   = cnt_q;
  assign out_flushed_o = flushed_q;
  assign ovf_o         = ovf_q;
  assign drop_count_o  = drop_q;

endmodule

// File: tb/tb_my_processor_nios2_qsys_dct_controller.sv
module tb_my_processor_nios2_qsys_dct_controller;

  localparam int MaxC = 15;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b1;
  logic        trace_valid_i = 1'b0;
  logic [1:0]  trace_sym_i = 2'd0;
  logic        flush_i = 1'b0;
  logic        out_ready_i = 1'b0;
  logic        ovf_clr_i = 1'b0;
  logic        out_valid_o;
  logic [29:0] dct_buffer_o;
  logic [3:0]  dct_count_o;
  logic        out_flushed_o;
  logic        ovf_o;
  logic [7:0]  drop_count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  my_processor_nios2_qsys_dct_controller #(.MaxCount(MaxC)) dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .trace_valid_i(trace_valid_i),
    .trace_sym_i  (trace_sym_i),
    .flush_i      (flush_i),
    .out_ready_i  (out_ready_i),
    .ovf_clr_i    (ovf_clr_i),
    .out_valid_o  (out_valid_o),
    .dct_buffer_o (dct_buffer_o),
    .dct_count_o  (dct_count_o),
    .out_flushed_o(out_flushed_o),
    .ovf_o        (ovf_o),
    .drop_count_o (drop_count_o)
  );

  // Reference model: accumulator as a queue of symbols, output as a held word.
  int          m_acc[$];
  bit          m_pend;
  bit          m_valid;
  logic [29:0] m_buf;
  logic [3:0]  m_cnt;
  bit          m_fl;
  bit          m_ovf;
  int          m_drop;

  function automatic logic [29:0] pack(input int q[$]);
    logic [29:0] w = '0;
    for (int i = 0; i < q.size(); i++) w = w | (30'(q[i]) << (2 * i));
    return w;
  endfunction

  function automatic void model_reset();
    m_acc.delete();
    m_pend = 0; m_valid = 0; m_buf = '0; m_cnt = '0; m_fl = 0; m_ovf = 0; m_drop = 0;
  endfunction

  function automatic void model_step(bit tv, bit [1:0] sym, bit fl, bit rdy, bit clr);
    bit free = !m_valid || rdy;
    bit fa = fl || m_pend;
    bit drop = 0;
    bit emit = 0;
    bit complete;
    if (m_acc.size() == MaxC) begin
      if (free) begin
        m_buf = pack(m_acc); m_cnt = 4'(MaxC); m_fl = 0; emit = 1;
        m_acc.delete(); m_pend = 0;
        if (tv) m_acc.push_back(int'(sym));
      end else begin
        drop = tv;
        m_pend = fa;
      end
    end else begin
      if (tv) m_acc.push_back(int'(sym));
      complete = (m_acc.size() == MaxC);
      if ((complete || (fa && m_acc.size() > 0)) && free) begin
        m_buf = pack(m_acc); m_cnt = 4'(m_acc.size()); m_fl = !complete; emit = 1;
        m_acc.delete(); m_pend = 0;
      end else begin
        m_pend = fa && (m_acc.size() > 0);
      end
    end
    if (emit) m_valid = 1;
    else if (rdy) m_valid = 0;
    if (clr) begin
      m_ovf = drop; m_drop = drop ? 1 : 0;
    end else if (drop) begin
      m_ovf = 1; if (m_drop < 255) m_drop++;
    end
  endfunction

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input bit tv, input bit [1:0] sym, input bit fl, input bit rdy,
                      input bit clr);
    trace_valid_i = tv; trace_sym_i = sym; flush_i = fl; out_ready_i = rdy; ovf_clr_i = clr;
    model_step(tv, sym, fl, rdy, clr);
    @(posedge clk_i);
    #1;
    trace_valid_i = 0; flush_i = 0; ovf_clr_i = 0;
  endtask

  task automatic do_reset();
    #1 reset_ni = 1'b0;
    model_reset();
    @(negedge clk_i);
    reset_ni = 1'b1;
  endtask

  task automatic test_reset();
    #1 reset_ni = 1'b0;
    model_reset();
    #1;
    checks += 5;
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid_o); end
    if (dct_buffer_o !== 30'd0) begin errors++; $display("FAIL reset_buf: got %0h want 0", dct_buffer_o); end
    if (dct_count_o !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", dct_count_o); end
    if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", ovf_o); end
    if (drop_count_o !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_count_o); end
    @(negedge clk_i);
    reset_ni = 1'b1;
  endtask

  task automatic test_full_word();
    for (int i = 0; i < MaxC; i++) begin
      step(1, 2'(i % 4), 0, 1, 0);
      if (i == MaxC - 2) begin
        checks++;
        if (out_valid_o !== 1'b0) begin errors++; $display("FAIL full_early: got %0b want 0", out_valid_o); end
      end
    end
    // Slots 0..14 = 0,1,2,3,... LSB-first: bytes 0xE4, top six bits 0b100100.
    checks += 4;
    if (out_valid_o !== 1'b1) begin errors++; $display("FAIL full_valid: got %0b want 1", out_valid_o); end
    if (dct_buffer_o !== 30'h24E4E4E4) begin errors++; $display("FAIL full_buf: got %0h want 24e4e4e4", dct_buffer_o); end
    if (dct_count_o !== 4'd15) begin errors++; $display("FAIL full_cnt: got %0d want 15", dct_count_o); end
    if (out_flushed_o !== 1'b0) begin errors++; $display("FAIL full_flushed: got %0b want 0", out_flushed_o); end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_flush();
    step(1, 2'd3, 0, 1, 0);
    step(1, 2'd2, 0, 1, 0);
    step(1, 2'd1, 0, 1, 0);
    step(0, 2'd0, 1, 1, 0);
    // 3 | 2<<2 | 1<<4
    checks += 4;
    if (out_valid_o !== 1'b1) begin errors++; $display("FAIL flush_valid: got %0b want 1", out_valid_o); end
    if (dct_buffer_o !== 30'h1B) begin errors++; $display("FAIL flush_buf: got %0h want 1b", dct_buffer_o); end
    if (dct_count_o !== 4'd3) begin errors++; $display("FAIL flush_cnt: got %0d want 3", dct_count_o); end
    if (out_flushed_o !== 1'b1) begin errors++; $display("FAIL flush_flushed: got %0b want 1", out_flushed_o); end
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    checks++;
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_empty: got %0b want 0", out_valid_o); end
  endtask

  task automatic test_flush_same_cycle();
    step(1, 2'd1, 0, 1, 0);
    step(1, 2'd2, 1, 1, 0);
    checks += 3;
    if (out_valid_o !== 1'b1) begin errors++; $display("FAIL fsame_valid: got %0b want 1", out_valid_o); end
    if (dct_count_o !== 4'd2) begin errors++; $display("FAIL fsame_cnt: got %0d want 2", dct_count_o); end
    if (dct_buffer_o !== 30'h9) begin errors++; $display("FAIL fsame_buf: got %0h want 9", dct_buffer_o); end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_stall_drop();
    do_reset();
    for (int i = 0; i < 40; i++) step(1, 2'd1, 0, 0, 0);
    checks += 5;
    if (out_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid: got %0b want 1", out_valid_o); end
    if (dct_count_o !== 4'd15) begin errors++; $display("FAIL stall_cnt: got %0d want 15", dct_count_o); end
    if (dct_buffer_o !== 30'h15555555) begin errors++; $display("FAIL stall_buf: got %0h want 15555555", dct_buffer_o); end
    if (drop_count_o !== 8'd10) begin errors++; $display("FAIL stall_drop: got %0d want 10", drop_count_o); end
    if (ovf_o !== 1'b1) begin errors++; $display("FAIL stall_ovf: got %0b want 1", ovf_o); end
    step(0, 0, 0, 0, 1);
    checks += 2;
    if (ovf_o !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %0b want 0", ovf_o); end
    if (drop_count_o !== 8'd0) begin errors++; $display("FAIL clr_drop: got %0d want 0", drop_count_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 35; i++) step(1, (i < 15) ? 2'd1 : 2'd3, 0, 0, 0);
    step(1, 2'd2, 0, 1, 0);
    checks += 4;
    if (out_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %0b want 1", out_valid_o); end
    if (dct_buffer_o !== 30'h3FFFFFFF) begin errors++; $display("FAIL b2b_buf: got %0h want 3fffffff", dct_buffer_o); end
    if (dct_count_o !== 4'd15) begin errors++; $display("FAIL b2b_cnt: got %0d want 15", dct_count_o); end
    if (drop_count_o !== 8'd5) begin errors++; $display("FAIL b2b_drop: got %0d want 5", drop_count_o); end
    step(0, 0, 1, 1, 0);
    checks += 3;
    if (dct_count_o !== 4'd1) begin errors++; $display("FAIL b2b_slot0_cnt: got %0d want 1", dct_count_o); end
    if (dct_buffer_o !== 30'h2) begin errors++; $display("FAIL b2b_slot0_buf: got %0h want 2", dct_buffer_o); end
    if (out_flushed_o !== 1'b1) begin errors++; $display("FAIL b2b_slot0_fl: got %0b want 1", out_flushed_o); end
    step(0, 0, 0, 1, 1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 22; i++) step(1, 2'd1, 0, (i < 15), 0);
    #2 reset_ni = 1'b0;
    model_reset();
    #1;
    checks += 4;
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %0b want 0", out_valid_o); end
    if (dct_buffer_o !== 30'd0) begin errors++; $display("FAIL rmid_buf: got %0h want 0", dct_buffer_o); end
    if (dct_count_o !== 4'd0) begin errors++; $display("FAIL rmid_cnt: got %0d want 0", dct_count_o); end
    if (out_flushed_o !== 1'b0) begin errors++; $display("FAIL rmid_fl: got %0b want 0", out_flushed_o); end
    @(negedge clk_i);
    reset_ni = 1'b1;
    for (int i = 0; i < MaxC; i++) step(1, 2'd2, 0, 1, 0);
    checks += 2;
    if (dct_buffer_o !== 30'h2AAAAAAA) begin errors++; $display("FAIL rmid_post_buf: got %0h want 2aaaaaaa", dct_buffer_o); end
    if (dct_count_o !== 4'd15) begin errors++; $display("FAIL rmid_post_cnt: got %0d want 15", dct_count_o); end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_random();
    int rdy_pct;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rdy_pct = (i % 400 == 0) ? 10 : 80;
      step($urandom_range(99) < 75, 2'($urandom), $urandom_range(99) < 8,
           $urandom_range(99) < rdy_pct, $urandom_range(99) < 2);
      checks += 3;
      if (out_valid_o !== m_valid) begin
        errors++; $display("FAIL rnd_valid cyc %0d: got %0b want %0b", i, out_valid_o, m_valid);
      end
      if (ovf_o !== m_ovf) begin
        errors++; $display("FAIL rnd_ovf cyc %0d: got %0b want %0b", i, ovf_o, m_ovf);
      end
      if (drop_count_o !== 8'(m_drop)) begin
        errors++; $display("FAIL rnd_drop cyc %0d: got %0d want %0d", i, drop_count_o, m_drop);
      end
      if (m_valid) begin
        checks += 3;
        if (dct_buffer_o !== m_buf) begin
          errors++; $display("FAIL rnd_buf cyc %0d: got %0h want %0h", i, dct_buffer_o, m_buf);
        end
        if (dct_count_o !== m_cnt) begin
          errors++; $display("FAIL rnd_cnt cyc %0d: got %0d want %0d", i, dct_count_o, m_cnt);
        end
        if (out_flushed_o !== m_fl) begin
          errors++; $display("FAIL rnd_fl cyc %0d: got %0b want %0b", i, out_flushed_o, m_fl);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_word();
    test_flush();
    test_flush_same_cycle();
    test_stall_drop();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
